// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file command sequencer: opcode and FSM state encodings.
package regfile_seq_pkg;

    localparam int unsigned DefWidth = 16;

    typedef enum logic [2:0] {
        OpMovi = 3'b000,
        OpMov  = 3'b001,
        OpAdd  = 3'b010,
        OpCmp  = 3'b011,
        OpAnd  = 3'b100,
        OpMvn  = 3'b101
    } op_t;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRda  = 3'd1,
        StRdb  = 3'd2,
        StExec = 3'd3,
        StWb   = 3'd4,
        StErr  = 3'd5
    } state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: result plus zero/negative/signed-overflow flags.
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = '0;
        v      = 1'b0;
        case (op)
            OpMov: result = b;
            OpMvn: result = ~b;
            OpAnd: result = a & b;
            OpAdd: begin
                result = sum;
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpCmp: begin
                result = diff;
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: result = '0;
        endcase
    end

    assign z = (result == '0);
    assign n = result[WIDTH-1];

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller that reads operands from the 8x16 register file, computes and writes back.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rn,
    input  logic [2:0]       cmd_rm,
    input  logic [IMM_W-1:0] cmd_imm,
    output logic [2:0]       rf_readnum,
    input  logic [WIDTH-1:0] rf_data_out,
    output logic [2:0]       rf_writenum,
    output logic             rf_write,
    output logic [WIDTH-1:0] rf_data_in,
    output logic             done,
    output logic             err,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, rd_q, rn_q, rm_q;
    logic [IMM_W-1:0] imm_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             z_q, n_q, v_q;

    logic             accept;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] alu_result;
    logic             alu_z, alu_n, alu_v;

    assign accept  = cmd_valid & cmd_ready;
    assign imm_ext = {{(WIDTH - IMM_W){imm_q[IMM_W-1]}}, imm_q};

    seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Route is chosen from the raw opcode on the accept edge so later states need no op decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OpMovi:       state_d = StWb;
                        OpMov, OpMvn: state_d = StRdb;
                        OpAdd, OpAnd,
                        OpCmp:        state_d = StRda;
                        default:      state_d = StErr;
                    endcase
                end
            end
            StRda:   state_d = StRdb;
            StRdb:   state_d = StExec;
            StExec:  state_d = (op_q == OpCmp) ? StIdle : StWb;
            StWb:    state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        rf_readnum  = 3'd0;
        rf_writenum = 3'd0;
        rf_write    = 1'b0;
        rf_data_in  = '0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StRda:  rf_readnum = rn_q;
            StRdb:  rf_readnum = rm_q;
            StExec: done = (op_q == OpCmp);
            StWb: begin
                rf_write    = 1'b1;
                rf_writenum = rd_q;
                rf_data_in  = (op_q == OpMovi) ? imm_ext : c_q;
                done        = 1'b1;
            end
            StErr:   err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 3'd0;
            rd_q  <= 3'd0;
            rn_q  <= 3'd0;
            rm_q  <= 3'd0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                rn_q  <= cmd_rn;
                rm_q  <= cmd_rm;
                imm_q <= cmd_imm;
            end
            if (state_q == StRda) begin
                a_q <= rf_data_out;
            end
            if (state_q == StRdb) begin
                b_q <= rf_data_out;
            end
            if (state_q == StExec) begin
                if (op_q != OpCmp) begin
                    c_q <= alu_result;
                end
                // MOV is the only EXEC-visiting op that preserves flags.
                if (op_q != OpMov) begin
                    z_q <= alu_z;
                    n_q <= alu_n;
                    v_q <= alu_v;
                end
            end
        end
    end

    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_v = v_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench: directed scenarios plus random commands checked against an architectural register model.
module tb_regfile_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rn, cmd_rm;
    logic [7:0]  cmd_imm;
    logic [2:0]  rf_readnum, rf_writenum;
    logic [15:0] rf_data_out, rf_data_in;
    logic        rf_write, done, err, flag_z, flag_n, flag_v;

    // Register file environment, with a bench-side preload port.
    logic [15:0] rf_mem [8];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;

    // Architectural reference state.
    logic [15:0] ref_regs [8];
    logic        ref_z, ref_n, ref_v;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_sequencer #(
        .WIDTH (16),
        .IMM_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_imm     (cmd_imm),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .done        (done),
        .err         (err),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_data_out = rf_mem[rf_readnum];

    always @(posedge clk) begin
        if (rf_write) begin
            rf_mem[rf_writenum] <= rf_data_in;
        end else if (pre_we) begin
            rf_mem[pre_addr] <= pre_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int addr, input logic [15:0] data);
        pre_addr = 3'(addr);
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_regs[addr] = data;
    endtask

    function automatic int exp_readnum(input int op, input int cyc, input int rn, input int rm);
        if (op == 2 || op == 3 || op == 4) begin
            if (cyc == 1) return rn;
            if (cyc == 2) return rm;
        end else if (op == 1 || op == 5) begin
            if (cyc == 1) return rm;
        end
        return 0;
    endfunction

    function automatic int to_signed16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input int op, input int rd, input int rn, input int rm, input int imm);
        int    a, b, sres, res, exp_lat, cyc, writes, wa_seen;
        bit    exp_wr, illegal, upd, got_done, got_err;
        logic [15:0] wd_seen;
        string sfx;

        sfx = $sformatf(" op%0d rd%0d rn%0d rm%0d", op, rd, rn, rm);
        a = int'(ref_regs[rn]);
        b = int'(ref_regs[rm]);
        exp_wr = 1'b1; illegal = 1'b0; upd = 1'b0; res = 0; sres = 0; exp_lat = 1;
        case (op)
            0: begin exp_lat = 1; res = (imm >= 128) ? imm - 256 + 65536 : imm; end
            1: begin exp_lat = 3; res = b; end
            2: begin
                exp_lat = 4; res = (a + b) % 65536; upd = 1'b1;
                sres = to_signed16(a) + to_signed16(b);
            end
            3: begin
                exp_lat = 3; exp_wr = 1'b0; res = (a - b + 65536) % 65536; upd = 1'b1;
                sres = to_signed16(a) - to_signed16(b);
            end
            4: begin exp_lat = 4; res = a & b; upd = 1'b1; end
            5: begin exp_lat = 3; res = 65535 - b; upd = 1'b1; end
            default: begin exp_lat = 1; exp_wr = 1'b0; illegal = 1'b1; end
        endcase

        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_rd    = 3'(rd);
        cmd_rn    = 3'(rn);
        cmd_rm    = 3'(rm);
        cmd_imm   = 8'(imm);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must work from latched fields.
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_rd    = 3'($urandom);
        cmd_rn    = 3'($urandom);
        cmd_rm    = 3'($urandom);
        cmd_imm   = 8'($urandom);

        got_done = 1'b0; got_err = 1'b0; writes = 0; cyc = 0; wa_seen = 0; wd_seen = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            cyc = i;
            check({"readnum", sfx}, {29'd0, rf_readnum}, 32'(exp_readnum(op, i, rn, rm)));
            if (rf_write) begin
                writes++;
                wa_seen = int'(rf_writenum);
                wd_seen = rf_data_in;
            end else begin
                check({"data_in_idle", sfx}, {16'd0, rf_data_in}, 32'd0);
            end
            if (done || err) begin
                got_done = done;
                got_err  = err;
                break;
            end
        end
        check({"latency", sfx}, 32'(cyc), 32'(exp_lat));
        check({"done", sfx}, {31'd0, got_done}, {31'd0, !illegal});
        check({"err", sfx}, {31'd0, got_err}, {31'd0, illegal});
        check({"write_count", sfx}, 32'(writes), {31'd0, exp_wr});
        if (exp_wr && writes == 1) begin
            check({"write_addr", sfx}, 32'(wa_seen), 32'(rd));
            check({"write_data", sfx}, {16'd0, wd_seen}, 32'(res));
        end

        if (upd) begin
            ref_z = (res == 0);
            ref_n = (res >= 32768);
            ref_v = (op == 2 || op == 3) && (sres > 32767 || sres < -32768);
        end
        if (exp_wr) ref_regs[rd] = 16'(res);

        @(negedge clk);
        check({"ready_after", sfx}, {31'd0, cmd_ready}, 32'd1);
        check({"pulse_end", sfx}, {30'd0, done, err}, 32'd0);
        check({"flags", sfx}, {29'd0, flag_z, flag_n, flag_v}, {29'd0, ref_z, ref_n, ref_v});
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rn    = '0;
        cmd_rm    = '0;
        cmd_imm   = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        ref_z = 1'b0; ref_n = 1'b0; ref_v = 1'b0;

        #2;
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_ctrl", {29'd0, rf_write, done, err}, 32'd0);
        check("reset_nums", {26'd0, rf_readnum, rf_writenum}, 32'd0);
        check("reset_data_in", {16'd0, rf_data_in}, 32'd0);
        check("reset_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);

        for (int r = 0; r < 8; r++) preload(r, 16'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test plan 1-5.
        run_cmd(0, 0, 0, 0, 8'h05);
        run_cmd(0, 1, 0, 0, 8'hFD);
        run_cmd(2, 2, 0, 1, 0);
        @(negedge clk);
        preload(3, 16'h7FFF);
        preload(4, 16'h0001);
        @(negedge clk);
        run_cmd(2, 5, 3, 4, 0);
        run_cmd(3, 0, 0, 0, 0);
        run_cmd(7, 6, 1, 2, 8'h33);
        run_cmd(6, 2, 3, 4, 8'h44);
        run_cmd(1, 6, 5, 5, 0);
        run_cmd(5, 7, 0, 0, 0);
        run_cmd(4, 3, 3, 5, 0);

        // Reset during RDB of an ADD.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rd = 3'd7; cmd_rn = 3'd1; cmd_rm = 3'd2;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_rdb", {29'd0, rf_readnum}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_outputs", {23'd0, rf_write, done, err, rf_readnum, rf_writenum}, 32'd0);
        check("abort_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        ref_z = 1'b0; ref_n = 1'b0; ref_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_write", {31'd0, rf_write}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        run_cmd(0, 4, 0, 0, 8'h80);

        // Random commands, back to back.
        for (int k = 0; k < 60; k++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 255)));
        end

        for (int r = 0; r < 8; r++) begin
            check($sformatf("final_reg%0d", r), {16'd0, rf_mem[r]}, {16'd0, ref_regs[r]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Multi-cycle controller that executes simple register-to-register commands against the 8x16 register file. Each command is accepted over a valid/ready handshake. The block then sequences the register file's single read port (readnum/data_out) and write port (writenum/write/data_in), latches operands A and B, computes a result C, and writes it back. It sits between the instruction decode logic and the register file, and owns all register file port timing.

Parameters:
WIDTH, 16, datapath width; must match the register file.
IMM_W, 8, immediate width; sign-extended to WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_op  input  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 illegal
cmd_rd  input  3  destination register
cmd_rn  input  3  first source register
cmd_rm  input  3  second source register
cmd_imm  input  IMM_W  immediate for MOVI
rf_readnum  output  3  register file read select
rf_data_out  input  WIDTH  register file combinational read data
rf_writenum  output  3  register file write select
rf_write  output  1  register file write enable
rf_data_in  output  WIDTH  register file write data
done  output  1  one-cycle pulse when a command completes
err  output  1  one-cycle pulse for an illegal opcode
flag_z  output  1  result zero
flag_n  output  1  result MSB
flag_v  output  1  signed overflow

Behaviour:
- Reset (async, rst_n=0): state IDLE; A, B, C, latched command fields and flags are all 0. rf_write, done and err are 0. rf_readnum and rf_writenum are 0. Reset mid-command aborts with no write.
- FSM states: IDLE, RDA, RDB, EXEC, WB, ERR.
- Accept: handshake in IDLE when cmd_valid & cmd_ready. All cmd_* fields are latched on that edge. Inputs are ignored outside IDLE.
- Transitions after accept, by op:
  - MOVI: WB.
  - MOV, MVN: RDB -> EXEC -> WB.
  - ADD, AND: RDA -> RDB -> EXEC -> WB.
  - CMP: RDA -> RDB -> EXEC -> IDLE.
  - Illegal op: ERR -> IDLE.
- RDA: rf_readnum = rn; A <= rf_data_out at the end of the cycle.
- RDB: rf_readnum = rm; B <= rf_data_out at the end of the cycle.
- rf_readnum is 0 in all other states.
- EXEC results:
  - MOV: C <= B.
  - MVN: C <= ~B.
  - ADD: C <= A + B.
  - AND: C <= A & B.
  - CMP: computes A - B; C is unchanged.
- Flags are registered in EXEC for ADD, CMP, AND and MVN; MOV and MOVI leave them unchanged.
  - Z = (result == 0); N = result[WIDTH-1].
  - V is signed overflow for ADD/CMP and 0 for AND/MVN.
  - Arithmetic is modulo 2^WIDTH.
- WB:
  - rf_write = 1, rf_writenum = rd.
  - rf_data_in = C, or the sign-extended imm for MOVI.
  - done = 1. Next state IDLE.
- done for CMP is asserted in EXEC.
- rf_write is asserted only in WB, and rf_data_in is 0 outside WB.
- All outputs are decoded from registered state and latched fields; there is no combinational path from cmd_* to rf_*.
- Latency, counted from the accept edge to the done cycle:
  - MOVI: 1.
  - MOV/MVN: 3.
  - ADD/AND: 4.
  - CMP: 3.
  - cmd_ready returns on the cycle after done.
- Back-to-back hazard: the register is written on the edge that ends WB. The next command's earliest read is at least 2 cycles later, so a read-after-write always sees the new value. No forwarding is needed.
- rd equal to rn or rm is legal; sources are read before writeback.
- ERR: err = 1 for one cycle; no register file write; flags unchanged.

Decomposition:
- Package regfile_seq_pkg holds:
  - op_t enum (opcode encodings above);
  - state_t enum (IDLE, RDA, RDB, EXEC, WB, ERR);
  - WIDTH default.
- One sub-module, seq_alu: combinational; inputs op, A, B; outputs result, z, n, v.

Test Plan:
1. Reset, then MOVI rd=0 imm=0x05 -> exactly one cycle after accept: rf_write=1, rf_writenum=0, rf_data_in=0x0005, done=1.
2. MOVI R1 imm=0xFD, then ADD rd=2 rn=0 rm=1 against a register file model -> in WB rf_data_in=0x0002, rf_writenum=2, done 4 cycles after accept. rf_readnum must be 0 in RDA and 1 in RDB. Flags Z=0, N=0, V=0.
3. Preload R3=0x7FFF and R4=0x0001; ADD rd=5 rn=3 rm=4 -> R5=0x8000, N=1, V=1, Z=0.
4. CMP rn=0 rm=0 with R0=5 -> Z=1, N=0, V=0. rf_write stays 0 throughout; done 3 cycles after accept.
5. cmd_op=111 -> err pulses one cycle after accept. No rf_write, flags unchanged, cmd_ready=1 on the following cycle.
6. Drive rst_n low during RDB of an ADD -> outputs reset immediately and rf_write never asserts. cmd_ready=1 after release; a subsequent MOVI completes normally.
